// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg : shared state encoding and helpers for multiplier_shift_add
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    localparam int MULT_STEPS = 16;

    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/Adder.sv
// ============================================================================
// Adder : 16-bit unsigned adder producing a 17-bit sum with carry out
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module Adder (
    input  logic [15:0] OperandoA,
    input  logic [15:0] OperandoB,
    output logic [16:0] Soma
);

    assign Soma = {1'b0, OperandoA} + {1'b0, OperandoB};

endmodule

`default_nettype wire

// File: rtl/multiplier_shift_add.sv
// ============================================================================
// multiplier_shift_add : sequential 16x16 shift-and-add multiplier, 17-cycle latency
// Rev 1.0  : initial release; MULT_SIGNED_EN selects two's-complement operands
// ============================================================================
`default_nettype none

module multiplier_shift_add
    import mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               St,
    input  logic [WIDTH-1:0]   Multiplicando,
    input  logic [WIDTH-1:0]   Multiplicador,
    output logic [2*WIDTH-1:0] Produto,
    output logic               Idle,
    output logic               Done
);

    // The datapath is welded to the 16-bit Adder, so any other width is refused.
    if (WIDTH != 16 || CNT_W < $clog2(MULT_STEPS + 1)) begin : g_param_check
        $fatal(1, "multiplier_shift_add: WIDTH must be 16 and CNT_W must hold MULT_STEPS");
    end

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(MULT_STEPS - 1);

    mult_state_e          state_q, state_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH:0]       w_soma;
    logic [2*WIDTH-1:0]   w_shift;
    logic [2*WIDTH-1:0]   w_final;
    logic [WIDTH-1:0]     w_load_m;
    logic [WIDTH-1:0]     w_load_p;

    Adder u_adder (
        .OperandoA (p_q[2*WIDTH-1:WIDTH]),
        .OperandoB (m_q),
        .Soma      (w_soma)
    );

    // The adder carry lands in the top bit, so no extra register bit is needed.
    assign w_shift = p_q[0] ? {w_soma, p_q[WIDTH-1:1]} : {1'b0, p_q[2*WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
    logic sign_q, sign_d;

    assign w_load_m = abs16(Multiplicando);
    assign w_load_p = abs16(Multiplicador);
    assign w_final  = sign_q ? -w_shift : w_shift;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end

    always_comb begin
        sign_d = sign_q;
        if (state_q == IDLE && St) begin
            sign_d = Multiplicando[WIDTH-1] ^ Multiplicador[WIDTH-1];
        end
    end
`else
    assign w_load_m = Multiplicando;
    assign w_load_p = Multiplicador;
    assign w_final  = w_shift;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    // Produto is loaded on the last step edge so it is valid during the Done cycle.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (St) begin
                    p_d     = {{WIDTH{1'b0}}, w_load_p};
                    m_d     = w_load_m;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                p_d   = w_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == c_last_step) begin
                    prod_d  = w_final;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Produto = prod_q;
    assign Idle    = (state_q == IDLE);
    assign Done    = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_multiplier_shift_add.sv
// ============================================================================
// tb_multiplier_shift_add : vector table, random model checks and corner sequences
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_multiplier_shift_add;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        St;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] Produto;
    logic        Idle;
    logic        Done;

    int n_checks = 0;
    int n_fail   = 0;

    // Edges from the accepting edge until Done is seen high.
    localparam int EXP_LAT = 16;

    multiplier_shift_add #(.WIDTH(16), .CNT_W(5)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .St            (St),
        .Multiplicando (A),
        .Multiplicador (B),
        .Produto       (Produto),
        .Idle          (Idle),
        .Done          (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_u;
        logic [31:0] exp_s;
        string       name;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        longint x;
        longint y;
`ifdef MULT_SIGNED_EN
        x = longint'($signed(a));
        y = longint'($signed(b));
`else
        x = longint'({16'd0, a});
        y = longint'({16'd0, b});
`endif
        return 32'(x * y);
    endfunction

    function automatic logic [31:0] table_exp(input vec_t v);
`ifdef MULT_SIGNED_EN
        return v.exp_s;
`else
        return v.exp_u;
`endif
    endfunction

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Called at a negedge while idle; poke_at>=0 raises St (A=B=7) in that busy cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int poke_at,
                          output logic [31:0] prod);
        int lat;
        A = a; B = b; St = 1'b1;
        step();
        St = 1'b0;
        A  = 16'($urandom);
        B  = 16'($urandom);
        check("busy_after_accept", {31'd0, Idle}, 32'd0);
        lat = 0;
        while (Done !== 1'b1 && lat < 40) begin
            if (lat == poke_at) begin
                St = 1'b1; A = 16'd7; B = 16'd7;
            end else begin
                St = 1'b0;
            end
            step();
            lat++;
        end
        St   = 1'b0;
        prod = Produto;
        check("latency", lat, EXP_LAT);
        step();
        check("done_width", {31'd0, Done}, 32'd0);
        check("idle_after_done", {31'd0, Idle}, 32'd1);
        check("produto_held", Produto, prod);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] p;
        logic [15:0] ra;
        logic [15:0] rb;
        int          lat;
        int          gap;
        int          done_seen;

        vecs[0] = '{16'd3,    16'd5,    32'd15,         32'd15,         "vec_3x5"};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001,   32'h00000001,   "vec_ffff_sq"};
        vecs[2] = '{16'h1234, 16'h0000, 32'h00000000,   32'h00000000,   "vec_zero"};
        vecs[3] = '{16'hFFFD, 16'd5,    32'h0004FFF1,   32'hFFFFFFF1,   "vec_m3x5"};
        vecs[4] = '{16'h8000, 16'h8000, 32'h40000000,   32'h40000000,   "vec_min_sq"};
        vecs[5] = '{16'h8000, 16'h0001, 32'h00008000,   32'hFFFF8000,   "vec_min_x1"};

        St = 1'b0; A = '0; B = '0; Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_produto", Produto, 32'd0);
        check("reset_idle", {31'd0, Idle}, 32'd1);
        check("reset_done", {31'd0, Done}, 32'd0);
        Reset_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, -1, p);
            check(vecs[i].name, p, table_exp(vecs[i]));
        end

        // Start request during CALC must not disturb the running product.
        run_op(16'd3, 16'd5, 5, p);
        check("busy_st_ignored", p, 32'd15);

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = (i % 7 == 0) ? 16'd0 : 16'($urandom);
            run_op(ra, rb, -1, p);
            check("random_vs_model", p, model(ra, rb));
        end

        // St held high: back-to-back operations, one idle cycle between them.
        A = 16'd9; B = 16'd11; St = 1'b1;
        step();
        lat = 0;
        while (Done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check("held_first_latency", lat, EXP_LAT);
        check("held_first_prod", Produto, 32'd99);
        gap = 0;
        do begin
            step();
            gap++;
            if (gap == 1) check("held_idle_slot", {31'd0, Idle}, 32'd1);
        end while (Done !== 1'b1 && gap < 60);
        St = 1'b0;
        check("held_gap", gap, EXP_LAT + 2);
        check("held_second_prod", Produto, 32'd99);
        step();
        check("held_back_idle", {31'd0, Idle}, 32'd1);

        // Asynchronous abort in the middle of an operation.
        A = 16'd3; B = 16'd5; St = 1'b1;
        step();
        St = 1'b0;
        repeat (8) step();
        #2 Reset_n = 1'b0;
        #1;
        check("abort_produto", Produto, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_idle", {31'd0, Idle}, 32'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (Done === 1'b1) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_op(16'd3, 16'd5, -1, p);
        check("restart_after_abort", p, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
